display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Shares the single FourDigitLEDdriver between two requesters: the receiver data path (decoded values) and the status/error path (error codes).
- Accepts 16-bit display words, four 4-bit digit codes: 0-9 digits, 4'hA '-', 4'hB 'F', 4'hC blank.
- Grants the display to one source and holds each word for a minimum visible time; arbitrates fairly when both are waiting.
- Output `signal_to_display` drives the driver port of the same name directly.

Parameters:
- HOLD_CYCLES, 5000: minimum clk cycles a granted word stays on display. Must be ≥1.
- CNT_W, 16: hold timer width. Must satisfy 2^CNT_W > HOLD_CYCLES.
- IDLE_CODE, 16'hCCCC: word shown after reset (all blanks).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  receiver word offered.
- rx_word  in  16  receiver display word.
- rx_ready  out  1  receiver slot free.
- err_valid  in  1  error word offered.
- err_word  in  16  error display word.
- err_ready  out  1  error slot free.
- signal_to_display  out  16  word to LED driver.
- disp_owner  out  2  source of shown word: 0 none, 1 rx, 2 err.
- hold_active  out  1  hold timer running.

Behaviour:
- Reset (reset=0, async) forces:
  - signal_to_display=IDLE_CODE, disp_owner=0, hold_active=0.
  - rx_ready=1, err_ready=1.
  - Both pending flags=0, timer=0, last_grant=err (so rx wins the first tie), state IDLE.
- Reset mid-hold discards the shown word and any pending words immediately.
- Per-source one-entry buffer:
  - ready = ~pend.
  - Transfer on a rising edge with valid&ready: buffer <= word, pend <= 1.
  - valid while ready=0 is ignored; the source must hold valid.
- State IDLE (hold_active=0):
  - On an edge with any pend=1, grant one source.
  - Grant means: signal_to_display <= buffer, disp_owner <= source, that pend <= 0, timer <= HOLD_CYCLES-1, state SHOW.
- State SHOW (hold_active=1):
  - Timer decrements each edge while nonzero.
  - On an edge with timer==0 and any pend: grant (reload timer); stay in SHOW.
  - On an edge with timer==0 and no pend: go to IDLE.
  - In IDLE, signal_to_display and disp_owner keep the last word; no blanking.
- Arbitration, at each grant point:
  - Only one pend: grant it.
  - Both pend: grant the source not equal to last_grant. last_grant updates on every grant.
  - No source can be starved for more than one hold period.
- Latency:
  - valid sampled at edge N sets pend.
  - Grant from IDLE occurs at edge N+1, so the display changes 2 cycles after valid is first seen high with ready.
- Simultaneous events:
  - A grant and a new accept for the same source cannot collide, because ready=0 while pend=1.
  - ready returns to 1 the cycle after the grant clears pend.
  - An accept of the other source on a grant edge is legal; that source becomes pending for the next grant point.
- HOLD_CYCLES=1: timer is loaded with 0, so a back-to-back grant is possible on the next edge and each word shows for exactly 1 cycle.
- Timer arithmetic is unsigned CNT_W-bit and never underflows (decrement gated by timer≠0).
- Outputs are registered; no combinational path from inputs to signal_to_display.

Test Plan (HOLD_CYCLES=4):
- Reset release, no requests, 20 cycles -> signal_to_display=16'hCCCC, disp_owner=0, rx_ready=err_ready=1 throughout.
- rx_valid pulse with 16'hA194 at edge N -> rx_ready=0 after N; signal_to_display=16'hA194 and disp_owner=1 after N+1; hold_active high 4 cycles, then 0 with word retained.
- rx 16'hCC10 and err 16'hBBBB both offered at the same edge after reset -> rx shown first (last_grant reset=err), 16'hBBBB exactly 4 cycles later, then IDLE.
- Continuous rx and err traffic for 40 cycles -> grants alternate rx/err every 4 cycles; never two consecutive grants to the same source while the other is pending.
- err word offered during an rx hold, with a 2nd err held valid while err_ready=0 -> 2nd word not accepted until the cycle after the 1st err is granted; no word lost or duplicated.
- reset asserted mid-hold while err pending -> immediate 16'hCCCC, disp_owner=0, pend cleared, ready=1; nothing is displayed after release until a new valid arrives.

Source files
------------

// File: rtl/display_arbiter.sv
// display_arbiter: shares one four-digit LED driver between the receiver
// data path and the status/error path. Each source has a one-word buffer;
// a granted word stays on the display for at least HOLD_CYCLES clocks and
// ties are broken by alternating away from the last granted source.
module display_arbiter #(
    parameter int          HOLD_CYCLES = 5000,
    parameter int          CNT_W       = 16,
    parameter logic [15:0] IDLE_CODE   = 16'hCCCC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [15:0] rx_word,
    output logic        rx_ready,
    input  logic        err_valid,
    input  logic [15:0] err_word,
    output logic        err_ready,
    output logic [15:0] signal_to_display,
    output logic [1:0]  disp_owner,
    output logic        hold_active
);

    typedef enum logic {
        IDLE,
        SHOW
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_RX   = 2'd1,
        OWN_ERR  = 2'd2
    } owner_t;

    // Reload value: the edge that grants counts as the first visible cycle.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              rx_pend_q, rx_pend_d;
    logic              err_pend_q, err_pend_d;
    logic [15:0]       rx_buf_q, err_buf_q;
    logic              last_err_q, last_err_d;   // 1: last grant went to err
    logic [15:0]       disp_q, disp_d;
    owner_t            owner_q, owner_d;

    logic              rx_accept, err_accept;
    logic              grant_point;
    logic              pick_rx, pick_err;

    assign rx_accept  = rx_valid  & ~rx_pend_q;
    assign err_accept = err_valid & ~err_pend_q;

    // A grant may happen when idle or when the running hold has expired.
    assign grant_point = (state_q == IDLE) || (timer_q == '0);

    // rx wins unless err is also pending and rx was granted last.
    assign pick_rx  = rx_pend_q & (~err_pend_q | last_err_q);
    assign pick_err = err_pend_q & ~pick_rx;

    // Next-state, timer, pending flags and display word.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        rx_pend_d  = rx_pend_q;
        err_pend_d = err_pend_q;
        last_err_d = last_err_q;
        disp_d     = disp_q;
        owner_d    = owner_q;

        if (rx_accept) begin
            rx_pend_d = 1'b1;
        end
        if (err_accept) begin
            err_pend_d = 1'b1;
        end

        if (!grant_point) begin
            timer_d = timer_q - CNT_ONE;
        end else if (pick_rx || pick_err) begin
            state_d    = SHOW;
            timer_d    = HOLD_LOAD;
            last_err_d = pick_err;
            disp_d     = pick_rx ? rx_buf_q : err_buf_q;
            owner_d    = pick_rx ? OWN_RX : OWN_ERR;
            // A pending source cannot accept on the same edge, so clearing
            // here never races with the set above.
            if (pick_rx) begin
                rx_pend_d = 1'b0;
            end else begin
                err_pend_d = 1'b0;
            end
        end else begin
            state_d = IDLE;
        end
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            rx_pend_q  <= 1'b0;
            err_pend_q <= 1'b0;
            last_err_q <= 1'b1;
            disp_q     <= IDLE_CODE;
            owner_q    <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rx_pend_q  <= rx_pend_d;
            err_pend_q <= err_pend_d;
            last_err_q <= last_err_d;
            disp_q     <= disp_d;
            owner_q    <= owner_d;
        end
    end

    // Capture offered words into the per-source buffers.
    always_ff @(posedge clk) begin
        // NOTE: payload buffers carry no reset; a buffer is only read when
        // its pending flag is set, which implies it was written first.
        if (rx_accept) begin
            rx_buf_q <= rx_word;
        end
        if (err_accept) begin
            err_buf_q <= err_word;
        end
    end

    assign rx_ready          = ~rx_pend_q;
    assign err_ready         = ~err_pend_q;
    assign signal_to_display = disp_q;
    assign disp_owner        = owner_q;
    assign hold_active       = (state_q == SHOW);

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: randomized and directed traffic into display_arbiter
// (HOLD_CYCLES=4). A transaction-level reference model pushes the expected
// output snapshot per clock into a queue; a monitor pops and compares.
module tb_display_arbiter;

    localparam int HOLD = 4;

    typedef struct packed {
        logic [15:0] disp;
        logic [1:0]  owner;
        logic        hold;
        logic        rxr;
        logic        errr;
    } snap_t;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [15:0] rx_word;
    logic        rx_ready;
    logic        err_valid;
    logic [15:0] err_word;
    logic        err_ready;
    logic [15:0] signal_to_display;
    logic [1:0]  disp_owner;
    logic        hold_active;

    int n_checks = 0;
    int n_err    = 0;

    snap_t exp_q[$];

    // Reference model state: source 1 = rx, source 2 = err.
    bit          m_pend[1:2];
    logic [15:0] m_buf[1:2];
    int          m_last;
    int          m_left;      // visible cycles left of the current word
    logic [15:0] m_disp;
    int          m_owner;

    // Driver handshake observations.
    bit rx_fire;
    bit err_fire;

    display_arbiter #(
        .HOLD_CYCLES(HOLD),
        .CNT_W      (16),
        .IDLE_CODE  (16'hCCCC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_valid         (rx_valid),
        .rx_word          (rx_word),
        .rx_ready         (rx_ready),
        .err_valid        (err_valid),
        .err_word         (err_word),
        .err_ready        (err_ready),
        .signal_to_display(signal_to_display),
        .disp_owner       (disp_owner),
        .hold_active      (hold_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_snapshot();
        snap_t s;
        s.disp  = m_disp;
        s.owner = 2'(m_owner);
        s.hold  = (m_left > 0);
        s.rxr   = !m_pend[1];
        s.errr  = !m_pend[2];
        exp_q.push_back(s);
    endtask

    // One clock of the reference model, from the behavioural rules.
    task automatic model_step();
        bit acc_rx;
        bit acc_err;
        int pick;
        if (!reset) begin
            m_pend[1] = 0;
            m_pend[2] = 0;
            m_last    = 2;
            m_left    = 0;
            m_disp    = 16'hCCCC;
            m_owner   = 0;
            exp_q.delete();
            push_snapshot();
        end else begin
            acc_rx  = rx_valid  && !m_pend[1];
            acc_err = err_valid && !m_pend[2];
            if (m_left <= 1) begin
                pick = 0;
                if (m_pend[1] && m_pend[2]) pick = (m_last == 1) ? 2 : 1;
                else if (m_pend[1])         pick = 1;
                else if (m_pend[2])         pick = 2;
                if (pick != 0) begin
                    m_disp       = m_buf[pick];
                    m_owner      = pick;
                    m_pend[pick] = 0;
                    m_last       = pick;
                    m_left       = HOLD;
                end else begin
                    m_left = 0;
                end
            end else begin
                m_left--;
            end
            if (acc_rx) begin
                m_pend[1] = 1;
                m_buf[1]  = rx_word;
            end
            if (acc_err) begin
                m_pend[2] = 1;
                m_buf[2]  = err_word;
            end
            push_snapshot();
        end
    endtask

    // Model advances on every clock edge and immediately on reset.
    always @(posedge clk or negedge reset) model_step();

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("signal_to_display", signal_to_display, e.disp);
            check("disp_owner", 16'(disp_owner), 16'(e.owner));
            check("hold_active", 16'(hold_active), 16'(e.hold));
            check("rx_ready", 16'(rx_ready), 16'(e.rxr));
            check("err_ready", 16'(err_ready), 16'(e.errr));
        end
    end

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++) w[4*i +: 4] = 4'($urandom_range(12, 0));
        return w;
    endfunction

    // One clock: note handshakes mid-cycle, return just after the edge.
    task automatic step();
        @(negedge clk);
        rx_fire  = rx_valid  && rx_ready  && reset;
        err_fire = err_valid && err_ready && reset;
        @(posedge clk);
        #1;
        if (rx_fire)  rx_valid  = 1'b0;
        if (err_fire) err_valid = 1'b0;
    endtask

    task automatic offer_rx(input logic [15:0] w);
        rx_valid = 1'b1;
        rx_word  = w;
    endtask

    task automatic offer_err(input logic [15:0] w);
        err_valid = 1'b1;
        err_word  = w;
    endtask

    task automatic wait_rx(input int limit);
        int k = 0;
        do begin
            step();
            k++;
        end while (!rx_fire && k < limit);
        if (!rx_fire) begin
            n_checks++;
            n_err++;
            $display("FAIL rx_accept_timeout: no accept within %0d cycles", limit);
            rx_valid = 1'b0;
        end
    endtask

    task automatic wait_err(input int limit);
        int k = 0;
        do begin
            step();
            k++;
        end while (!err_fire && k < limit);
        if (!err_fire) begin
            n_checks++;
            n_err++;
            $display("FAIL err_accept_timeout: no accept within %0d cycles", limit);
            err_valid = 1'b0;
        end
    endtask

    // Random traffic; a source that is offering holds its word until taken.
    task automatic run(input int n, input int rx_pct, input int err_pct);
        for (int i = 0; i < n; i++) begin
            step();
            if (!rx_valid && $urandom_range(99, 0) < rx_pct) offer_rx(rand_word());
            if (!err_valid && $urandom_range(99, 0) < err_pct) offer_err(rand_word());
        end
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b0;
        rx_valid  = 1'b0;
        err_valid = 1'b0;
        repeat (n) step();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        rx_valid  = 1'b0;
        rx_word   = '0;
        err_valid = 1'b0;
        err_word  = '0;
        repeat (3) step();
        reset = 1'b1;

        // Idle after reset: blanks, no owner, both slots free.
        run(20, 0, 0);

        // Single rx word, hold then idle with word retained.
        offer_rx(16'hA194);
        wait_rx(5);
        run(10, 0, 0);

        // Simultaneous offers right after reset: rx first, then err.
        do_reset(2);
        offer_rx(16'hCC10);
        offer_err(16'hBBBB);
        step();
        run(14, 0, 0);

        // Continuous traffic from both sources.
        run(40, 100, 100);
        run(12, 0, 0);

        // err during rx hold, second err held while err slot is full.
        offer_rx(16'h1357);
        wait_rx(10);
        step();
        offer_err(16'h2468);
        wait_err(10);
        offer_err(16'h9BA0);
        wait_err(30);
        run(15, 0, 0);

        // Reset mid-hold with err pending.
        offer_rx(16'h1234);
        wait_rx(10);
        step();
        offer_err(16'hA0A0);
        wait_err(10);
        do_reset(2);
        run(12, 0, 0);

        // Mixed random traffic.
        run(400, 30, 30);
        run(15, 0, 0);

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
